// File: rtl/dec_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: walks the unmasked channels in ascending
// order, holding each for DWELL cycles, in single-pass or continuous mode.
module dec_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [7:0] mask,
    output logic [2:0] a,
    output logic       En,
    output logic       busy,
    output logic       ch_tick,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    a_q, a_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mask_q, mask_d;
    logic          cont_q, cont_d;

    logic [2:0]    lo_in_ch;
    logic [2:0]    lo_lat_ch;
    logic [2:0]    hi_ch;
    logic          hi_found;
    logic          last_cycle;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        lowest_set = '0;
        // Descending walk so the final hit is the lowest set bit.
        for (int unsigned i = 0; i < 8; i++) begin
            idx = 3'(7 - i);
            if (m[idx]) lowest_set = idx;
        end
    endfunction

    always_comb begin
        logic [2:0] idx;
        hi_ch    = '0;
        hi_found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = 3'(7 - i);
            if (mask_q[idx] && (idx > a_q)) begin
                hi_ch    = idx;
                hi_found = 1'b1;
            end
        end
    end

    assign lo_in_ch   = lowest_set(mask);
    assign lo_lat_ch  = lowest_set(mask_q);
    assign last_cycle = (cnt_q == CW'(DWELL - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        en_d    = 1'b0;
        busy_d  = 1'b0;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        cont_d  = cont_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop && (mask != '0)) begin
                    state_d = ST_SCAN;
                    mask_d  = mask;
                    cont_d  = cont;
                    a_d     = lo_in_ch;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    tick_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (stop) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (last_cycle) begin
                    if (hi_found || cont_q) begin
                        a_d    = hi_found ? hi_ch : lo_lat_ch;
                        en_d   = 1'b1;
                        busy_d = 1'b1;
                        tick_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
        end
    end

    assign a       = a_q;
    assign En      = en_q;
    assign busy    = busy_q;
    assign ch_tick = tick_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Scoreboard bench for dec_scan_ctrl: stimulus queues expected output cycles,
// a negedge monitor pops and compares whenever En or done is presented.
module tb_dec_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, cont;
    logic [7:0] mask;
    logic [2:0] a;
    logic       En, busy, ch_tick, done;

    logic       start1, stop1, cont1;
    logic [7:0] mask1;
    logic [2:0] a1;
    logic       En1, busy1, ch_tick1, done1;

    typedef struct {
        logic [2:0] a;
        logic       tick;
        logic       done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ntests = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

    dec_scan_ctrl #(.DWELL(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .mask(mask), .a(a), .En(En), .busy(busy), .ch_tick(ch_tick), .done(done)
    );

    dec_scan_ctrl #(.DWELL(1), .CW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .cont(cont1),
        .mask(mask1), .a(a1), .En(En1), .busy(busy1), .ch_tick(ch_tick1), .done(done1)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Packed view {a, En, busy, ch_tick, done}; expected En/busy are the inverse of done.
    function automatic void pop_cmp(input int which, input logic [6:0] act);
        exp_t e;
        logic [6:0] req;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_output dut%0d actual=%h required=none (t=%0t)", which, act, $time);
            return;
        end
        e   = (which == 0) ? q0.pop_front() : q1.pop_front();
        req = {e.a, !e.done, !e.done, e.tick, e.done};
        check((which == 0) ? "scan_out_dwell4" : "scan_out_dwell1", 32'(act), 32'(req));
    endfunction

    always @(negedge clk) begin
        if (En || done)   pop_cmp(0, {a, En, busy, ch_tick, done});
        if (En1 || done1) pop_cmp(1, {a1, En1, busy1, ch_tick1, done1});
    end

    task automatic push_ch(input int which, input logic [2:0] ch, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.a = ch; e.tick = (i == 0); e.done = 1'b0;
            if (which == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic push_done(input int which, input logic [2:0] ch);
        exp_t e;
        e.a = ch; e.tick = 1'b0; e.done = 1'b1;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Returns on the negedge where the first scan cycle is visible.
    task automatic start_scan(input logic [7:0] m, input logic c);
        @(negedge clk);
        mask = m; cont = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; cont = 1'b0; mask = '0;
        start1 = 1'b0; stop1 = 1'b0; cont1 = 1'b0; mask1 = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({a, En, busy, ch_tick, done}), 32'd0);
        check("reset_outputs_dwell1", 32'({a1, En1, busy1, ch_tick1, done1}), 32'd0);
        rst_n = 1'b1;

        // Reset mid-dwell on channel 1 of a continuous full scan
        push_ch(0, 3'd0, 4);
        push_ch(0, 3'd1, 2);
        start_scan(8'hFF, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset_mid_scan", 32'({a, En, busy, ch_tick, done}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full single pass
        for (int c = 0; c < 8; c++) push_ch(0, 3'(c), 4);
        push_done(0, 3'd7);
        start_scan(8'hFF, 1'b0);
        repeat (36) @(negedge clk);
        check("idle_after_full_pass", 32'({En, busy, done}), 32'd0);

        // Sparse mask 2,5,7
        push_ch(0, 3'd2, 4);
        push_ch(0, 3'd5, 4);
        push_ch(0, 3'd7, 4);
        push_done(0, 3'd7);
        start_scan(8'hA4, 1'b0);
        repeat (16) @(negedge clk);

        // Continuous 0,7 wrap, stopped in the second cycle of the second a=7 dwell
        push_ch(0, 3'd0, 4);
        push_ch(0, 3'd7, 4);
        push_ch(0, 3'd0, 4);
        push_ch(0, 3'd7, 2);
        push_done(0, 3'd7);
        start_scan(8'h81, 1'b1);
        repeat (13) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_stop", 32'({En, busy, done}), 32'd0);

        // start with empty mask is ignored
        mask = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_mask_zero", 32'({En, busy, ch_tick, done}), 32'd0);
        repeat (2) @(negedge clk);

        // start and stop together: stop wins
        mask = 8'hFF; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start_and_stop_idle", 32'({En, busy, ch_tick, done}), 32'd0);
        repeat (3) @(negedge clk);

        // Mask change and start pulse during scan do not disturb the latched pass
        push_ch(0, 3'd1, 4);
        push_ch(0, 3'd2, 4);
        push_done(0, 3'd2);
        start_scan(8'h06, 1'b0);
        @(negedge clk);
        mask = 8'h01; cont = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("idle_after_relatched_attempt", 32'({En, busy, done}), 32'd0);

        // DWELL=1 instance: channel changes every cycle
        for (int c = 0; c < 4; c++) push_ch(1, 3'(c), 1);
        push_done(1, 3'd3);
        @(negedge clk);
        mask1 = 8'h0F; cont1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (8) @(negedge clk);

        check("scoreboard_drained_dwell4", 32'(q0.size()), 32'd0);
        check("scoreboard_drained_dwell1", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
